// File: rtl/uart_pkg.sv
// uart_pkg: shared types, oversampling constants and the parity helper
// for the UART transceiver.
//   parity_e    - frame parity mode as carried on cfg_parity
//   tx_state_e  - transmitter FSM states
//   rx_state_e  - receiver FSM states
//   frame_parity(data, nbits, mode) - parity bit for the low nbits of data
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_EVEN  = 2'd1,
        PAR_ODD   = 2'd2,
        PAR_NONE3 = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    function automatic logic parity_enabled(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Mode 3 behaves as "none", so only EVEN and ODD produce a non-zero bit.
    function automatic logic frame_parity(input logic [15:0] data,
                                          input logic [3:0]  nbits,
                                          input parity_e     mode);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(nbits)) begin
                acc = acc ^ data[i];
            end
        end
        case (mode)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_transceiver_if.sv
// uart_transceiver_if: byte-level handshakes between the register front-end
// (master) and the UART (slave).
//   tx_data/tx_valid/tx_ready          - transmit word handshake
//   rx_data/rx_valid/rx_ready          - receive word handshake
//   rx_frame_err/rx_parity_err/rx_break - per-frame status, qualified by rx_valid
//   rx_overrun                          - one-cycle pulse, a completed frame was dropped
interface uart_transceiver_if #(
    parameter int MAX_BITS = 9
) ();
    logic [MAX_BITS-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [MAX_BITS-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                rx_frame_err;
    logic                rx_parity_err;
    logic                rx_break;
    logic                rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err,
               rx_break, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err,
               rx_break, rx_overrun
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversample tick generator.
//   clk, rst_n - clock, asynchronous active-low reset
//   baud_div   - tick period minus one (clk/(baud*16)-1)
//   tick       - one-cycle pulse every baud_div+1 clocks
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == '0) begin
            cnt_reg <= baud_div;
        end else begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    // Ticking on zero means baud_div=0 ticks every cycle.
    assign tick = (cnt_reg == '0);

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART with run-time frame configuration.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   baud_div                   - oversample tick period minus one
//   cfg_data_bits/cfg_parity/cfg_stop2 - frame format, latched per frame
//   bus (slave)                - tx/rx word handshakes and rx status flags
//   tx                         - serial output, idle high
//   rx                         - serial input, asynchronous to clk
//   rx_busy                    - receiver not idle
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int MAX_BITS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [3:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    uart_transceiver_if.slave bus,
    output logic             tx,
    input  logic             rx,
    output logic             rx_busy
);
    localparam logic [3:0] MAX_NBITS = 4'(MAX_BITS);

    logic       tick;
    logic [3:0] cfg_nbits;
    parity_e    cfg_par;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_div (baud_div),
        .tick     (tick)
    );

    // Illegal data-bit counts fall back to 8.
    assign cfg_nbits = (cfg_data_bits >= 4'd5 && cfg_data_bits <= MAX_NBITS) ? cfg_data_bits : 4'd8;
    assign cfg_par   = parity_e'(cfg_parity);

    // ---------------------------------------------------------------- TX
    tx_state_e           tx_state_reg, tx_state_next;
    logic [4:0]          tx_tick_reg, tx_tick_next, tx_bit_last;
    logic [3:0]          tx_bit_reg, tx_bit_next;
    logic [MAX_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic [3:0]          tx_nbits_reg, tx_nbits_next;
    parity_e             tx_par_mode_reg, tx_par_mode_next;
    logic                tx_stop2_reg, tx_stop2_next;
    logic                tx_par_bit_reg, tx_par_bit_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg    <= TX_IDLE;
            tx_tick_reg     <= '0;
            tx_bit_reg      <= '0;
            tx_shift_reg    <= '0;
            tx_nbits_reg    <= 4'd8;
            tx_par_mode_reg <= PAR_NONE;
            tx_stop2_reg    <= 1'b0;
            tx_par_bit_reg  <= 1'b0;
        end else begin
            tx_state_reg    <= tx_state_next;
            tx_tick_reg     <= tx_tick_next;
            tx_bit_reg      <= tx_bit_next;
            tx_shift_reg    <= tx_shift_next;
            tx_nbits_reg    <= tx_nbits_next;
            tx_par_mode_reg <= tx_par_mode_next;
            tx_stop2_reg    <= tx_stop2_next;
            tx_par_bit_reg  <= tx_par_bit_next;
        end
    end

    always_comb begin
        tx_state_next    = tx_state_reg;
        tx_tick_next     = tx_tick_reg;
        tx_bit_next      = tx_bit_reg;
        tx_shift_next    = tx_shift_reg;
        tx_nbits_next    = tx_nbits_reg;
        tx_par_mode_next = tx_par_mode_reg;
        tx_stop2_next    = tx_stop2_reg;
        tx_par_bit_next  = tx_par_bit_reg;
        tx_bit_last      = (tx_state_reg == TX_STOP && tx_stop2_reg) ?
                           5'(2*OVERSAMPLE-1) : 5'(OVERSAMPLE-1);
        case (tx_state_reg)
            TX_IDLE: begin
                if (bus.tx_valid) begin
                    tx_state_next    = TX_START;
                    tx_tick_next     = '0;
                    tx_shift_next    = bus.tx_data;
                    tx_nbits_next    = cfg_nbits;
                    tx_par_mode_next = cfg_par;
                    tx_stop2_next    = cfg_stop2;
                    tx_par_bit_next  = frame_parity(16'(bus.tx_data), cfg_nbits, cfg_par);
                end
            end
            TX_START, TX_DATA, TX_PARITY, TX_STOP: begin
                if (tick) begin
                    if (tx_tick_reg == tx_bit_last) begin
                        tx_tick_next = '0;
                        case (tx_state_reg)
                            TX_START: begin
                                tx_state_next = TX_DATA;
                                tx_bit_next   = '0;
                            end
                            TX_DATA: begin
                                tx_shift_next = tx_shift_reg >> 1;
                                tx_bit_next   = tx_bit_reg + 4'd1;
                                if (tx_bit_reg == tx_nbits_reg - 4'd1) begin
                                    tx_state_next = parity_enabled(tx_par_mode_reg) ? TX_PARITY : TX_STOP;
                                end
                            end
                            TX_PARITY: tx_state_next = TX_STOP;
                            default:   tx_state_next = TX_IDLE;
                        endcase
                    end else begin
                        tx_tick_next = tx_tick_reg + 5'd1;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // Decoded straight from state so reset forces the line high at once.
    always_comb begin
        tx = 1'b1;
        case (tx_state_reg)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = tx_shift_reg[0];
            TX_PARITY: tx = tx_par_bit_reg;
            default:   tx = 1'b1;
        endcase
    end

    assign bus.tx_ready = (tx_state_reg == TX_IDLE);

    // ---------------------------------------------------------------- RX
    logic                rx_s1_reg, rx_s2_reg;
    rx_state_e           rx_state_reg, rx_state_next;
    logic [3:0]          rx_tick_reg, rx_tick_next;
    logic [3:0]          rx_bit_reg, rx_bit_next;
    logic [MAX_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic [3:0]          rx_nbits_reg, rx_nbits_next;
    parity_e             rx_par_mode_reg, rx_par_mode_next;
    logic [1:0]          rx_samp_reg, rx_samp_next;
    logic                rx_par_bit_reg, rx_par_bit_next;
    logic                rx_any_high_reg, rx_any_high_next;
    logic                rx_wait_high_reg, rx_wait_high_next;
    logic                rx_maj;
    logic                frame_done, frame_err_c, parity_err_c, break_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_reg        <= 1'b1;
            rx_s2_reg        <= 1'b1;
            rx_state_reg     <= RX_IDLE;
            rx_tick_reg      <= '0;
            rx_bit_reg       <= '0;
            rx_shift_reg     <= '0;
            rx_nbits_reg     <= 4'd8;
            rx_par_mode_reg  <= PAR_NONE;
            rx_samp_reg      <= '0;
            rx_par_bit_reg   <= 1'b0;
            rx_any_high_reg  <= 1'b0;
            rx_wait_high_reg <= 1'b0;
        end else begin
            rx_s1_reg        <= rx;
            rx_s2_reg        <= rx_s1_reg;
            rx_state_reg     <= rx_state_next;
            rx_tick_reg      <= rx_tick_next;
            rx_bit_reg       <= rx_bit_next;
            rx_shift_reg     <= rx_shift_next;
            rx_nbits_reg     <= rx_nbits_next;
            rx_par_mode_reg  <= rx_par_mode_next;
            rx_samp_reg      <= rx_samp_next;
            rx_par_bit_reg   <= rx_par_bit_next;
            rx_any_high_reg  <= rx_any_high_next;
            rx_wait_high_reg <= rx_wait_high_next;
        end
    end

    // The third vote is the live synchronized sample at the SAMPLE_HI tick.
    assign rx_maj = (rx_samp_reg[0] & rx_samp_reg[1]) |
                    (rx_samp_reg[0] & rx_s2_reg) |
                    (rx_samp_reg[1] & rx_s2_reg);

    always_comb begin
        rx_state_next     = rx_state_reg;
        rx_tick_next      = rx_tick_reg;
        rx_bit_next       = rx_bit_reg;
        rx_shift_next     = rx_shift_reg;
        rx_nbits_next     = rx_nbits_reg;
        rx_par_mode_next  = rx_par_mode_reg;
        rx_samp_next      = rx_samp_reg;
        rx_par_bit_next   = rx_par_bit_reg;
        rx_any_high_next  = rx_any_high_reg;
        rx_wait_high_next = rx_wait_high_reg;
        frame_done        = 1'b0;
        frame_err_c       = 1'b0;
        parity_err_c      = 1'b0;
        break_c           = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_s2_reg) begin
                    rx_wait_high_next = 1'b0;
                end
                // After a low stop bit the line must go high before a new start counts.
                if (!rx_s2_reg && !rx_wait_high_reg) begin
                    rx_state_next    = RX_START;
                    rx_tick_next     = '0;
                    rx_bit_next      = '0;
                    rx_shift_next    = '0;
                    rx_nbits_next    = cfg_nbits;
                    rx_par_mode_next = cfg_par;
                    rx_any_high_next = 1'b0;
                end
            end
            RX_START, RX_DATA, RX_PARITY, RX_STOP: begin
                if (tick) begin
                    rx_tick_next = rx_tick_reg + 4'd1;
                    if (rx_tick_reg == 4'(SAMPLE_LO)) begin
                        rx_samp_next[0] = rx_s2_reg;
                    end
                    if (rx_tick_reg == 4'(SAMPLE_MID)) begin
                        rx_samp_next[1] = rx_s2_reg;
                    end
                    if (rx_tick_reg == 4'(SAMPLE_HI)) begin
                        case (rx_state_reg)
                            RX_START: begin
                                if (rx_maj) begin
                                    rx_state_next = RX_IDLE;
                                end
                            end
                            RX_DATA: begin
                                rx_shift_next[rx_bit_reg] = rx_maj;
                                rx_any_high_next = rx_any_high_reg | rx_maj;
                            end
                            RX_PARITY: begin
                                rx_par_bit_next  = rx_maj;
                                rx_any_high_next = rx_any_high_reg | rx_maj;
                            end
                            default: begin
                                // Leaving mid stop bit leaves room for back-to-back frames.
                                frame_done        = 1'b1;
                                frame_err_c       = ~rx_maj;
                                parity_err_c      = parity_enabled(rx_par_mode_reg) &&
                                                    (rx_par_bit_reg != frame_parity(16'(rx_shift_reg),
                                                                                    rx_nbits_reg,
                                                                                    rx_par_mode_reg));
                                break_c           = ~rx_any_high_reg & ~rx_maj;
                                rx_wait_high_next = ~rx_maj;
                                rx_state_next     = RX_IDLE;
                            end
                        endcase
                    end
                    if (rx_tick_reg == 4'(OVERSAMPLE-1)) begin
                        case (rx_state_reg)
                            RX_START: begin
                                rx_state_next = RX_DATA;
                                rx_bit_next   = '0;
                            end
                            RX_DATA: begin
                                rx_bit_next = rx_bit_reg + 4'd1;
                                if (rx_bit_reg == rx_nbits_reg - 4'd1) begin
                                    rx_state_next = parity_enabled(rx_par_mode_reg) ? RX_PARITY : RX_STOP;
                                end
                            end
                            RX_PARITY: rx_state_next = RX_STOP;
                            default: ;
                        endcase
                    end
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign rx_busy = (rx_state_reg != RX_IDLE);

    // ---------------------------------------------------- RX output register
    logic [MAX_BITS-1:0] rx_data_reg;
    logic                rx_valid_reg, rx_frame_err_reg, rx_parity_err_reg;
    logic                rx_break_reg, rx_overrun_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_reg       <= '0;
            rx_valid_reg      <= 1'b0;
            rx_frame_err_reg  <= 1'b0;
            rx_parity_err_reg <= 1'b0;
            rx_break_reg      <= 1'b0;
            rx_overrun_reg    <= 1'b0;
        end else begin
            rx_overrun_reg <= 1'b0;
            if (frame_done) begin
                // A same-cycle handshake frees the slot, so the new word wins.
                if (!rx_valid_reg || bus.rx_ready) begin
                    rx_data_reg       <= rx_shift_reg;
                    rx_frame_err_reg  <= frame_err_c;
                    rx_parity_err_reg <= parity_err_c;
                    rx_break_reg      <= break_c;
                    rx_valid_reg      <= 1'b1;
                end else begin
                    rx_overrun_reg <= 1'b1;
                end
            end else if (rx_valid_reg && bus.rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = rx_data_reg;
    assign bus.rx_valid      = rx_valid_reg;
    assign bus.rx_frame_err  = rx_frame_err_reg;
    assign bus.rx_parity_err = rx_parity_err_reg;
    assign bus.rx_break      = rx_break_reg;
    assign bus.rx_overrun    = rx_overrun_reg;

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed scenario bench for uart_transceiver.
// baud_div=3 throughout, so one bit is 16*4 = 64 clocks.
module tb_uart_transceiver;

    localparam int MAX_BITS = 9;
    localparam int DIV_W    = 16;
    localparam int BIT_CYC  = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIV_W-1:0] baud_div;
    logic [3:0]       cfg_data_bits;
    logic [1:0]       cfg_parity;
    logic             cfg_stop2;
    logic             tx;
    logic             rx_drv;
    logic             loop_en;
    logic             rx_line;
    logic             rx_busy;

    int tests = 0;
    int fails = 0;
    int ovr_total = 0;

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx : rx_drv;

    uart_transceiver_if #(.MAX_BITS(MAX_BITS)) bus ();

    uart_transceiver #(.DIV_W(DIV_W), .MAX_BITS(MAX_BITS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_div      (baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .bus           (bus),
        .tx            (tx),
        .rx            (rx_line),
        .rx_busy       (rx_busy)
    );

    always @(negedge clk) begin
        if (bus.rx_overrun === 1'b1) ovr_total++;
    end

    // Accept a word, check tx low on the next cycle, then check each wire bit mid-bit.
    task automatic send_tx_check(input string name, input logic [8:0] data,
                                 input logic [11:0] exp, input int nwire);
        @(negedge clk);
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        tests++;
        if (tx !== 1'b0 || bus.tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_accept: tx=%b tx_ready=%b, expected 0 0", name, tx, bus.tx_ready);
        end
        repeat (BIT_CYC/2) @(negedge clk);
        for (int i = 0; i < nwire; i++) begin
            tests++;
            if (tx !== exp[i]) begin
                fails++;
                $display("FAIL %s_bit%0d: tx=%b, expected %b", name, i, tx, exp[i]);
            end
            if (i < nwire - 1) repeat (BIT_CYC) @(negedge clk);
        end
        $display("[TB] tx %s data=0x%03h", name, data);
    endtask

    task automatic drive_bit(input logic b, input bit glitch);
        for (int c = 0; c < BIT_CYC; c++) begin
            rx_drv = (glitch && c >= 34 && c < 38) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic drive_rx_frame(input logic [8:0] data, input int nbits, input bit has_par,
                                  input logic par, input int nstop, input int glitch_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(data[i], i == glitch_bit);
        if (has_par) drive_bit(par, 1'b0);
        for (int s = 0; s < nstop; s++) drive_bit(1'b1, 1'b0);
        rx_drv = 1'b1;
    endtask

    task automatic wait_rx_valid(input string name, input int budget);
        int n;
        n = 0;
        while (bus.rx_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.rx_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_valid: rx_valid=%b after %0d cycles, expected 1", name, bus.rx_valid, n);
        end
    endtask

    task automatic check_rx(input string name, input logic [8:0] data,
                            input logic fe, input logic pe, input logic brk);
        tests++;
        if (bus.rx_data !== data || bus.rx_frame_err !== fe ||
            bus.rx_parity_err !== pe || bus.rx_break !== brk) begin
            fails++;
            $display("FAIL %s_rx: data=0x%03h fe=%b pe=%b brk=%b, expected 0x%03h %b %b %b",
                     name, bus.rx_data, bus.rx_frame_err, bus.rx_parity_err, bus.rx_break,
                     data, fe, pe, brk);
        end
        $display("[TB] rx %s data=0x%03h fe=%b pe=%b brk=%b", name, bus.rx_data,
                 bus.rx_frame_err, bus.rx_parity_err, bus.rx_break);
    endtask

    task automatic consume_rx(input string name);
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        tests++;
        if (bus.rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_consume: rx_valid=%b, expected 0", name, bus.rx_valid);
        end
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic st2);
        cfg_data_bits = nb;
        cfg_parity    = par;
        cfg_stop2     = st2;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_tx: tx=%b tx_ready=%b rx_busy=%b, expected 1 1 0", tx, bus.tx_ready, rx_busy);
        end
        tests++;
        if (bus.rx_valid !== 1'b0 || bus.rx_data !== 9'h000 || bus.rx_overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_rx: rx_valid=%b rx_data=0x%03h rx_overrun=%b, expected 0 0x000 0",
                     bus.rx_valid, bus.rx_data, bus.rx_overrun);
        end
        check_rx("reset", 9'h000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_8n1();
        int ovr0;
        set_cfg(4'd8, 2'd0, 1'b0);
        loop_en = 1'b1;
        ovr0 = ovr_total;
        // wire: start 0, 0xA5 LSB first 1,0,1,0,0,1,0,1, stop 1
        send_tx_check("8n1", 9'h0A5, 12'h34A, 10);
        wait_rx_valid("8n1", 300);
        check_rx("8n1", 9'h0A5, 1'b0, 1'b0, 1'b0);
        tests++;
        if (ovr_total != ovr0) begin
            fails++;
            $display("FAIL 8n1_overrun: pulses=%0d, expected 0", ovr_total - ovr0);
        end
        consume_rx("8n1");
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic test_parity();
        set_cfg(4'd7, 2'd2, 1'b1);
        loop_en = 1'b1;
        // wire: start, 1,0,1,0,1,0,1, odd parity 1, stop, stop
        send_tx_check("7o2", 9'h055, 12'h7AA, 11);
        wait_rx_valid("7o2", 300);
        check_rx("7o2", 9'h055, 1'b0, 1'b0, 1'b0);
        consume_rx("7o2");
        repeat (BIT_CYC) @(negedge clk);
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        drive_rx_frame(9'h055, 7, 1'b1, 1'b0, 2, -1);
        wait_rx_valid("7o2_bad_par", 300);
        check_rx("7o2_bad_par", 9'h055, 1'b0, 1'b1, 1'b0);
        consume_rx("7o2_bad_par");
    endtask

    task automatic test_overrun();
        int ovr0;
        set_cfg(4'd8, 2'd0, 1'b0);
        loop_en = 1'b0;
        ovr0 = ovr_total;
        drive_rx_frame(9'h011, 8, 1'b0, 1'b0, 1, -1);
        drive_rx_frame(9'h022, 8, 1'b0, 1'b0, 1, -1);
        repeat (BIT_CYC) @(negedge clk);
        tests++;
        if (bus.rx_valid !== 1'b1) begin
            fails++;
            $display("FAIL overrun_valid: rx_valid=%b, expected 1", bus.rx_valid);
        end
        check_rx("overrun", 9'h011, 1'b0, 1'b0, 1'b0);
        tests++;
        if (ovr_total - ovr0 != 1) begin
            fails++;
            $display("FAIL overrun_pulse: pulses=%0d, expected 1", ovr_total - ovr0);
        end
        consume_rx("overrun");
    endtask

    task automatic test_glitch();
        set_cfg(4'd8, 2'd0, 1'b0);
        loop_en = 1'b0;
        rx_drv  = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (rx_busy !== 1'b1) begin
            fails++;
            $display("FAIL glitch_start_seen: rx_busy=%b, expected 1", rx_busy);
        end
        repeat (6) @(negedge clk);
        rx_drv = 1'b1;
        repeat (100) @(negedge clk);
        tests++;
        if (rx_busy !== 1'b0 || bus.rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL glitch_false_start: rx_busy=%b rx_valid=%b, expected 0 0", rx_busy, bus.rx_valid);
        end
        $display("[TB] rx false_start rx_busy=%b", rx_busy);
        drive_rx_frame(9'h03C, 8, 1'b0, 1'b0, 1, 3);
        wait_rx_valid("glitch_bit3", 300);
        check_rx("glitch_bit3", 9'h03C, 1'b0, 1'b0, 1'b0);
        consume_rx("glitch_bit3");
    endtask

    task automatic test_break();
        bit         seen;
        logic [8:0] cap_data;
        logic       cap_fe, cap_brk;
        set_cfg(4'd8, 2'd0, 1'b0);
        loop_en = 1'b0;
        seen = 1'b0;
        cap_data = 9'h1FF;
        cap_fe = 1'b0;
        cap_brk = 1'b0;
        rx_drv = 1'b0;
        for (int c = 0; c < 12*BIT_CYC; c++) begin
            @(negedge clk);
            if (bus.rx_valid === 1'b1 && !seen) begin
                seen         = 1'b1;
                cap_data     = bus.rx_data;
                cap_fe       = bus.rx_frame_err;
                cap_brk      = bus.rx_break;
                bus.rx_ready = 1'b1;
            end else begin
                bus.rx_ready = 1'b0;
            end
        end
        tests++;
        if (!seen || cap_data !== 9'h000 || cap_fe !== 1'b1 || cap_brk !== 1'b1) begin
            fails++;
            $display("FAIL break_frame: seen=%b data=0x%03h fe=%b brk=%b, expected 1 0x000 1 1",
                     seen, cap_data, cap_fe, cap_brk);
        end
        $display("[TB] rx break data=0x%03h fe=%b brk=%b", cap_data, cap_fe, cap_brk);
        tests++;
        if (rx_busy !== 1'b0 || bus.rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL break_hold_low: rx_busy=%b rx_valid=%b, expected 0 0", rx_busy, bus.rx_valid);
        end
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        tests++;
        if (bus.rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL break_release: rx_valid=%b, expected 0", bus.rx_valid);
        end
        drive_rx_frame(9'h05A, 8, 1'b0, 1'b0, 1, -1);
        wait_rx_valid("after_break", 300);
        check_rx("after_break", 9'h05A, 1'b0, 1'b0, 1'b0);
        consume_rx("after_break");
    endtask

    task automatic test_back_to_back();
        int   cyc;
        bit   got_ready;
        logic stop_mid;
        set_cfg(4'd8, 2'd0, 1'b0);
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        @(negedge clk);
        bus.tx_data  = 9'h0A5;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (BIT_CYC/2 + 2*BIT_CYC) @(negedge clk);
        tests++;
        if (tx !== 1'b0) begin
            fails++;
            $display("FAIL rst_pre: tx=%b in data bit 1, expected 0", tx);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (tx !== 1'b1 || bus.tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_async: tx=%b tx_ready=%b, expected 1 1", tx, bus.tx_ready);
        end
        $display("[TB] tx reset_mid_frame tx=%b tx_ready=%b", tx, bus.tx_ready);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        set_cfg(4'd9, 2'd0, 1'b0);
        bus.tx_data  = 9'h1FF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data = 9'h000;
        tests++;
        if (tx !== 1'b0) begin
            fails++;
            $display("FAIL b2b_start1: tx=%b, expected 0", tx);
        end
        cyc = 0;
        got_ready = 1'b0;
        stop_mid = 1'b0;
        while (!got_ready && cyc < 800) begin
            @(negedge clk);
            cyc++;
            if (cyc == BIT_CYC/2 + 10*BIT_CYC) stop_mid = tx;
            if (bus.tx_ready === 1'b1) got_ready = 1'b1;
        end
        @(negedge clk);
        cyc++;
        bus.tx_valid = 1'b0;
        tests++;
        if (!got_ready || tx !== 1'b0 || stop_mid !== 1'b1 || cyc < 702 || cyc > 705) begin
            fails++;
            $display("FAIL b2b_gap: ready=%b tx=%b stop=%b start_to_start=%0d, expected 1 0 1 702..705",
                     got_ready, tx, stop_mid, cyc);
        end
        $display("[TB] tx b2b 0x1FF then 0x000 start_to_start=%0d", cyc);
        repeat (BIT_CYC/2 + 5*BIT_CYC) @(negedge clk);
        tests++;
        if (tx !== 1'b0) begin
            fails++;
            $display("FAIL b2b_frame2_data: tx=%b in data bit 4, expected 0", tx);
        end
        repeat (6*BIT_CYC) @(negedge clk);
        tests++;
        if (bus.tx_ready !== 1'b1 || tx !== 1'b1) begin
            fails++;
            $display("FAIL b2b_end: tx_ready=%b tx=%b, expected 1 1", bus.tx_ready, tx);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        baud_div      = 16'd3;
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'd0;
        cfg_stop2     = 1'b0;
        rx_drv        = 1'b1;
        loop_en       = 1'b0;
        bus.tx_data   = '0;
        bus.tx_valid  = 1'b0;
        bus.rx_ready  = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_overrun();
        test_glitch();
        test_break();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Full-duplex UART with run-time frame configuration, valid/ready byte handshakes and a 16x-oversampled majority-vote receiver. It is the next-generation replacement for the fixed-parameter UART driver: baud rate, data width, parity and stop bits are register inputs instead of elaboration constants. Receive errors are reported per frame. It sits between the register/bus front-end and the chip pins.

## Interface
- `DIV_W`, 16: width of the baud divisor input.
- `MAX_BITS`, 9: width of the data ports; the maximum data bits per frame.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud_div`  in  DIV_W  oversample tick period minus one, i.e. clk/(baud*16)-1.
- `cfg_data_bits`  in  4  data bits per frame, 5..MAX_BITS. Out-of-range values are clamped to 8.
- `cfg_parity`  in  2  parity mode: 0 none, 1 even, 2 odd, 3 treated as none.
- `cfg_stop2`  in  1  0: one stop bit; 1: two stop bits.
- `tx_data`  in  MAX_BITS  word to send, LSB first; unused MSBs are ignored.
- `tx_valid`  in  1  transmit request.
- `tx_ready`  out  1  transmitter idle; a word is accepted on `tx_valid && tx_ready`.
- `tx`  out  1  serial output, idle high.
- `rx`  in  1  serial input, asynchronous.
- `rx_data`  out  MAX_BITS  received word, zero-extended.
- `rx_valid`  out  1  `rx_data` and the error flags are valid.
- `rx_ready`  in  1  consumer accepts the received word.
- `rx_frame_err`  out  1  first stop bit sampled low; qualified by `rx_valid`.
- `rx_parity_err`  out  1  parity mismatch; qualified by `rx_valid`.
- `rx_break`  out  1  all data bits, parity and stop sampled low; qualified by `rx_valid`.
- `rx_overrun`  out  1  one-cycle pulse when a completed frame is dropped.
- `rx_busy`  out  1  receiver is not in IDLE.

## Operation
- **Tick generator:**
  - Down-counter reloaded with `baud_div`.
  - `tick` pulses one cycle every `baud_div`+1 clocks. `baud_div`=0 gives a tick every cycle.
  - Free-running; shared by TX and RX.
- **TX FSM:** IDLE, START, DATA, PARITY, STOP.
  - `tx_ready` = (state==IDLE).
  - On accept, `tx_data`, `cfg_*` and the parity value are latched. Config changes mid-frame have no effect.
  - Each bit lasts 16 ticks. The DATA bit count equals the latched data-bit count.
  - PARITY is skipped when parity is none.
  - STOP lasts 16 or 32 ticks, then returns to IDLE.
  - Even parity: `tx` = XOR of the data bits. Odd parity: its inverse.
- **RX front end:** 2-flop synchronizer on `rx`, reset value 1.
- **RX FSM:** IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on a synchronized low. Config is latched at that point and the tick counter is zeroed.
  - Within each bit, samples are taken at ticks 7, 8 and 9. The bit value is the majority of the three.
  - START: if the majority is 1, it is a false start; return to IDLE with no output.
  - Only the first stop bit is checked. The FSM returns to IDLE at its tick 9 sample, which allows back-to-back frames with one stop bit.
- **RX output register:**
  - On stop-bit evaluation, if `rx_valid`=0: load `rx_data` and the error flags, and set `rx_valid`.
  - If `rx_valid`=1 at that point: keep the old word and pulse `rx_overrun`.
  - `rx_valid` clears on `rx_valid && rx_ready`.
  - If a frame completes in the same cycle as the handshake, the new word is loaded and `rx_valid` stays 1; there is no overrun.

## Timing
- **Reset values:**
  - `tx`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, all error flags 0, `rx_busy`=0.
  - Both FSMs in IDLE; tick counter 0.
  - Reset asserted mid-frame aborts immediately; `tx` returns to 1 asynchronously.
- **TX latency and duration:**
  - `tx` goes low on the clock after accept.
  - Frame length is (1+N+P+S)·16·(`baud_div`+1) cycles.
  - `tx_ready` rises on the cycle after the last stop tick. The next word may be accepted on that cycle, with no idle gap.
- **RX latency:**
  - `rx_valid` asserts 2 (sync) + 1 cycle after the tick-9 sample of the stop bit.
  - Start-edge detection uncertainty is at most 1 tick.
- **Frame tolerance:** majority sampling tolerates one glitched sample per bit. Baud mismatch of ±3% is the required tolerance.

## Structure
- Package `uart_pkg` holds:
  - `parity_e`, `tx_state_e`, `rx_state_e`.
  - `OVERSAMPLE`=16, `SAMPLE_LO`=7, `SAMPLE_MID`=8, `SAMPLE_HI`=9.
  - Function `frame_parity(data, nbits, mode)`.
- Sub-module `uart_baud_gen` contains the tick generator only. TX and RX logic stay in `uart_transceiver`.

## Test plan
- **8N1:** `baud_div`=3, 8N1, send 0xA5 → `tx` waveform 0,1,0,1,0,0,1,0,1,1 with each bit lasting 64 clk; looped back, `rx_data`=0x0A5, no errors.
- **Odd parity, 7 bits, 2 stop:** 0x55 with 7-bit odd parity, 2 stop → parity bit 1 on `tx`; loopback clean. Force the parity bit inverted on `rx` → `rx_parity_err`=1, data still 0x55.
- **Overrun:** hold `rx_ready`=0 and receive 0x11 then 0x22 → `rx_data`=0x11, one `rx_overrun` pulse. Raise `rx_ready` → `rx_valid` drops.
- **Glitches:** `rx` low pulse shorter than 8 ticks → no `rx_valid`, `rx_busy` returns to 0. Single-sample glitch at tick 8 of data bit 3 → data unaffected.
- **Break:** `rx` held low for 12 bit-times → `rx_valid` with `rx_data`=0, `rx_frame_err`=1, `rx_break`=1. Receiver waits for high before the next start.
- **Reset and back-to-back TX:** `rst_n` low mid-TX data bit → `tx`=1 and `tx_ready`=1 immediately. After release, back-to-back words 9N1 0x1FF, 0x000 → no idle gap between frames.
